regfile_cmd_sequencer: RTL and testbench
========================================

// Module: regfile_cmd_sequencer
// PURPOSE
//   Hardware initiator for the RegFile_wrapper load interface. Buffers board-level
//   commands and replays each one as a timed ld_Setup / ld_Reg / ld_Imm / en sequence.
//   Each sequence holds data_input stable before, during and after a single-cycle strobe.
//   Sits between the switch/button front end (or a scripted source) and RegFile_wrapper.
//   Replaces hand-timed strobing with a buffered, protocol-correct command stream.
// PARAMETERS
//   DATA_W      10  width of command payload / data_out (matches wrapper data_input)
//   FIFO_DEPTH  4   command buffer entries (power of two, >= 2)
//   GAP_CYCLES  1   idle cycles after strobe/en with data_out held (>= 1)
//   EN_CYCLES   1   cycles en is held high for an EXEC command (>= 1)
// PORTS
//   clk         in   1                 system clock, rising edge
//   rst_n       in   1                 asynchronous active-low reset
//   cmd_valid   in   1                 command offered this cycle
//   cmd_ready   out  1                 buffer can accept; transfer = cmd_valid & cmd_ready
//   cmd_op      in   2                 00 SETUP, 01 REG, 10 IMM, 11 EXEC
//   cmd_data    in   DATA_W            payload (ignored for EXEC)
//   data_out    out  DATA_W            to wrapper data_input
//   ld_Setup    out  1                 one-cycle strobe for SETUP
//   ld_Reg      out  1                 one-cycle strobe for REG
//   ld_Imm      out  1                 one-cycle strobe for IMM
//   en          out  1                 execute enable, EN_CYCLES wide
//   busy        out  1                 FSM not IDLE or buffer non-empty
//   fifo_count  out  clog2(DEPTH)+1    entries currently buffered
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - All strobes, en and data_out = 0; busy = 0; fifo_count = 0.
//     - cmd_ready = 1 once rst_n deasserts.
//     - FIFO is emptied and the FSM forced to IDLE immediately, even mid-sequence.
//     - An in-flight strobe drops on the assertion edge, not at the next clock.
//   All outputs are registered; no combinational path from cmd_* to any output.
//   Buffer:
//     - cmd_ready = (fifo_count < FIFO_DEPTH), computed from registered count.
//     - A push while full is never accepted, even if a pop happens in the same cycle.
//     - Simultaneous push and pop leaves fifo_count unchanged.
//     - Pointers wrap modulo FIFO_DEPTH.
//   FSM states: IDLE -> PREP -> FIRE -> HOLD -> IDLE.
//     - IDLE: if fifo_count != 0, pop the head; data_out <= payload (unchanged for EXEC);
//       go to PREP.
//     - PREP: one cycle; data_out stable, no strobe; go to FIRE.
//     - FIRE:
//       - SETUP/REG/IMM: exactly one strobe high for exactly 1 cycle.
//       - EXEC: en high for EN_CYCLES consecutive cycles (internal counter).
//       - Then go to HOLD.
//     - HOLD: GAP_CYCLES cycles, all strobes 0, data_out held; then IDLE.
//   Timing:
//     - Push accepted at edge E0 into an empty buffer with the FSM in IDLE:
//       pop at E1, strobe high from E2 to E3.
//     - IDLE->IDLE minimum command period = 3+GAP_CYCLES (+EN_CYCLES-1 for EXEC).
//   Invariants:
//     - At most one of ld_Setup/ld_Reg/ld_Imm/en is high in any cycle.
//     - data_out never changes in the cycle a strobe or en is high.
//     - Commands issue strictly in acceptance order.
//   cmd_valid deasserting while not ready has no effect; no partial transfers.
// TESTING
//   1. Reset: rst_n=0 mid-FIRE of an IMM command -> ld_Imm=0 immediately.
//      After rst_n=1: fifo_count=0, busy=0, cmd_ready=1, data_out=0.
//   2. Single SETUP 0x080 pushed at E0 -> data_out=0x080 from E1.
//      ld_Setup high only E2..E3; busy drops after E3+GAP_CYCLES.
//   3. Back-to-back SETUP 0x000, REG 0x001, IMM 0x001, SETUP 0x090, EXEC ->
//      strobes appear in that order, one-hot, each spaced 3+GAP_CYCLES cycles.
//      en high EN_CYCLES cycles with data_out=0x090.
//   4. Push 5 commands with the FSM stalled at DEPTH=4 -> cmd_ready=0 after the 4th.
//      5th accepted only after the first pop; no commands lost or duplicated.
//   5. Push on the same edge as a pop with count=2 -> count stays 2, order preserved.
//   6. EXEC with EN_CYCLES=3 -> en high exactly 3 cycles, no ld_* asserted.
//      Every cycle checks the one-hot invariant via assertion.

Source files
------------

// File: rtl/regfile_cmd_sequencer_if.sv
// Command and RegFile_wrapper load bus for the command sequencer.
// The master side offers commands and observes the load strobes; the
// slave side is the sequencer itself.
interface regfile_cmd_sequencer_if #(
    parameter int DATA_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] data_out;
    logic              ld_Setup;
    logic              ld_Reg;
    logic              ld_Imm;
    logic              en;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, data_out, ld_Setup, ld_Reg, ld_Imm, en
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, data_out, ld_Setup, ld_Reg, ld_Imm, en
    );
endinterface

// File: rtl/regfile_cmd_sequencer.sv
// Buffered initiator for the RegFile_wrapper load interface. Commands are
// queued in a small FIFO and replayed as PREP -> FIRE -> HOLD sequences so
// data_out is stable before, during and after every strobe / en pulse.
module regfile_cmd_sequencer #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1,
    parameter int EN_CYCLES  = 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_cmd_sequencer_if.slave  bus,
    output logic                    busy,
    output logic [CNT_W-1:0]        fifo_count
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int TMR_MAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [1:0] OP_SETUP = 2'b00;
    localparam logic [1:0] OP_REG   = 2'b01;
    localparam logic [1:0] OP_IMM   = 2'b10;
    localparam logic [1:0] OP_EXEC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_FIRE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Command storage: {op, payload} per entry
    logic [DATA_W+1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data_out;
    logic              r_ld_setup;
    logic              r_ld_reg;
    logic              r_ld_imm;
    logic              r_en;
    logic              r_busy;
    logic [TMR_W-1:0]  r_tmr;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W+1:0] w_head;
    logic [1:0]        w_head_op;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_fsm_idle_next;

    // Readiness comes only from the registered count, so a pop in the same
    // cycle can never let a push into a full buffer.
    assign w_ready   = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push    = bus.cmd_valid && w_ready;
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_op = w_head[DATA_W+1:DATA_W];

    assign w_fsm_idle_next = ((r_state == ST_IDLE) && !w_pop) ||
                             ((r_state == ST_HOLD) && (r_tmr == '0));

    // Occupancy after this edge; push and pop together cancel out
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Buffer payload write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_data};
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // Registered busy: FSM leaving IDLE or anything still queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= !w_fsm_idle_next || (w_count_next != '0);
        end
    end

    // Sequencer FSM with registered data_out, strobes and en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_SETUP;
            r_data_out <= '0;
            r_ld_setup <= 1'b0;
            r_ld_reg   <= 1'b0;
            r_ld_imm   <= 1'b0;
            r_en       <= 1'b0;
            r_tmr      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_op <= w_head_op;
                        // EXEC carries no payload, so the last value stays on the bus
                        if (w_head_op != OP_EXEC) begin
                            r_data_out <= w_head[DATA_W-1:0];
                        end
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_state <= ST_FIRE;
                    case (r_op)
                        OP_SETUP: r_ld_setup <= 1'b1;
                        OP_REG:   r_ld_reg   <= 1'b1;
                        OP_IMM:   r_ld_imm   <= 1'b1;
                        default: begin
                            r_en  <= 1'b1;
                            r_tmr <= TMR_W'(EN_CYCLES - 1);
                        end
                    endcase
                end
                ST_FIRE: begin
                    if (r_en && (r_tmr != '0)) begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end else begin
                        r_ld_setup <= 1'b0;
                        r_ld_reg   <= 1'b0;
                        r_ld_imm   <= 1'b0;
                        r_en       <= 1'b0;
                        r_tmr      <= TMR_W'(GAP_CYCLES - 1);
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_tmr == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.data_out  = r_data_out;
    assign bus.ld_Setup  = r_ld_setup;
    assign bus.ld_Reg    = r_ld_reg;
    assign bus.ld_Imm    = r_ld_imm;
    assign bus.en        = r_en;
    assign busy          = r_busy;
    assign fifo_count    = r_count;
endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Bench for regfile_cmd_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a queue-and-timeline reference.
module tb_regfile_cmd_sequencer;
    localparam int DW    = 10;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int ENC   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [CW-1:0] fifo_count;

    regfile_cmd_sequencer_if #(.DATA_W(DW)) bus();

    regfile_cmd_sequencer #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .EN_CYCLES(ENC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: command queue plus the timeline of the command in flight
    cmd_t          m_q[$];
    int            k = 0;
    int            m_free = 0;
    int            m_idle_at = 0;
    int            m_start = -100;
    int            m_len = 0;
    logic [1:0]    m_op = 2'd0;
    logic [DW-1:0] m_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_free    = 0;
        m_idle_at = 0;
        m_start   = -100;
        m_len     = 0;
        m_op      = 2'd0;
        m_dout    = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(bus.data_out), 0);
        chk({tag, "_ld_setup"}, 32'(bus.ld_Setup), 0);
        chk({tag, "_ld_reg"},   32'(bus.ld_Reg), 0);
        chk({tag, "_ld_imm"},   32'(bus.ld_Imm), 0);
        chk({tag, "_en"},       32'(bus.en), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_count"},    32'(fifo_count), 0);
    endtask

    // One clock: drive inputs, advance the reference at the edge, compare
    task automatic step(input bit v, input logic [1:0] op, input logic [DW-1:0] d, output bit acc);
        int   sz;
        bit   pop;
        bit   act;
        cmd_t c;
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        k++;
        sz  = m_q.size();
        pop = (k >= m_free) && (sz > 0);
        acc = v && (sz < DEPTH);
        if (pop) begin
            c = m_q.pop_front();
            m_op = c.op;
            if (c.op != 2'd3) m_dout = c.data;
            m_start   = k + 1;
            m_len     = (c.op == 2'd3) ? ENC : 1;
            m_idle_at = k + 1 + m_len + GAP;
            m_free    = m_idle_at + 1;
            $display("ISSUE edge=%0d op=%0d data=%03h", k, c.op, c.data);
        end
        if (acc) begin
            m_q.push_back(cmd_t'{op: op, data: d});
            $display("PUSH  edge=%0d op=%0d data=%03h depth=%0d", k, op, d, m_q.size());
        end
        #1;
        act = (k >= m_start) && (k < m_start + m_len);
        chk("data_out",  32'(bus.data_out), 32'(m_dout));
        chk("ld_setup",  32'(bus.ld_Setup), 32'(act && m_op == 2'd0));
        chk("ld_reg",    32'(bus.ld_Reg),   32'(act && m_op == 2'd1));
        chk("ld_imm",    32'(bus.ld_Imm),   32'(act && m_op == 2'd2));
        chk("en",        32'(bus.en),       32'(act && m_op == 2'd3));
        chk("busy",      32'(busy),         32'((k < m_idle_at) || (m_q.size() != 0)));
        chk("fifo_count", 32'(fifo_count),  32'(m_q.size()));
        chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() < DEPTH));
        chk("onehot", 32'($countones({bus.ld_Setup, bus.ld_Reg, bus.ld_Imm, bus.en}) <= 1), 1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom), DW'($urandom), a);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 200; i++) begin
            if (m_q.size() == 0 && k >= m_idle_at) break;
            step(1'b0, 2'd0, '0, a);
        end
        chk("drain_done", 32'(m_q.size() == 0 && k >= m_idle_at), 1);
    endtask

    // Offer one command, holding valid until accepted (bounded)
    task automatic push_hold(input logic [1:0] op, input logic [DW-1:0] d);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 60 && !a; i++) step(1'b1, op, d, a);
        chk("push_accepted", 32'(a), 1);
    endtask

    initial begin
        bit a;
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = '0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rst_n = 1'b1;
        #1;
        chk("por_ready", 32'(bus.cmd_ready), 1);

        // Reset asserted while an IMM strobe is high
        step(1'b1, 2'd2, 10'h155, a);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 2'd0, '0, a);
            seen = (bus.ld_Imm === 1'b1);
        end
        chk("imm_strobe_seen", 32'(seen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midfire");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("post_rst");
        chk("post_rst_ready", 32'(bus.cmd_ready), 1);

        // Single SETUP
        step(1'b1, 2'd0, 10'h080, a);
        idle(8);
        drain();

        // Back-to-back SETUP, REG, IMM, SETUP, EXEC
        step(1'b1, 2'd0, 10'h000, a);
        step(1'b1, 2'd1, 10'h001, a);
        step(1'b1, 2'd2, 10'h001, a);
        step(1'b1, 2'd0, 10'h090, a);
        step(1'b1, 2'd3, 10'h3ff, a);
        drain();

        // Fill behind a long EXEC: ready drops after the 4th queued entry
        step(1'b1, 2'd3, 10'h000, a);
        push_hold(2'd0, 10'h011);
        push_hold(2'd1, 10'h022);
        push_hold(2'd2, 10'h033);
        push_hold(2'd0, 10'h044);
        chk("full_ready_low", 32'(bus.cmd_ready), 0);
        push_hold(2'd1, 10'h055);
        drain();

        // Push on the same edge as a pop with two entries queued
        step(1'b1, 2'd0, 10'h101, a);
        step(1'b1, 2'd1, 10'h102, a);
        step(1'b1, 2'd2, 10'h103, a);
        for (int i = 0; i < 20 && (k + 1 < m_free); i++) step(1'b0, 2'd0, '0, a);
        step(1'b1, 2'd0, 10'h104, a);
        chk("simul_push_pop_count", 32'(fifo_count), 2);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), 2'($urandom), DW'($urandom), a);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
